// File: rtl/control_unit.sv
// control_unit: Moore sequencer for S = ((A*X)+B)*X + C on the shared operative datapath.
// Latency: start sampled in IDLE -> done high 6 cycles later (LOAD_X, 4 ALU steps, DONE).
// Backpressure: none; start is ignored while busy. Build option OVERFLOW_ABORT_EN aborts to ERROR on ALU overflow.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       zero,
    input  logic       overflow,
    output logic       LX,
    output logic       LS,
    output logic       LH,
    output logic       H,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       zero_flag,
    output logic       ovf_flag
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        MUL_A  = 3'd2,
        ADD_B  = 3'd3,
        MUL_X  = 3'd4,
        ADD_C  = 3'd5,
        DONE   = 3'd6,
        ERROR  = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    // The four states in which the ALU result is written into Reg_S.
    logic alu_state;
    // Overflow that diverts the sequence to ERROR (never, unless the abort policy is built in).
    logic abort;

    assign alu_state = (state == MUL_A) || (state == ADD_B) ||
                       (state == MUL_X) || (state == ADD_C);

`ifdef OVERFLOW_ABORT_EN
    assign abort = overflow;
`else
    assign abort = 1'b0;
`endif

    // State register; synchronous active-low reset returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a fixed walk through the ALU steps, with an optional overflow exit to ERROR.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = start ? LOAD_X : IDLE;
            LOAD_X:  state_next = MUL_A;
            MUL_A:   state_next = abort ? ERROR : ADD_B;
            ADD_B:   state_next = abort ? ERROR : MUL_X;
            MUL_X:   state_next = abort ? ERROR : ADD_C;
            ADD_C:   state_next = abort ? ERROR : DONE;
            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the registered state only; every output defaults to 0.
    always_comb begin
        LX   = 1'b0;
        LS   = 1'b0;
        LH   = 1'b0;
        H    = 1'b0;
        M0   = 2'b00;
        M1   = 2'b00;
        M2   = 2'b00;
        busy = (state != IDLE);
        done = 1'b0;
        err  = 1'b0;
        case (state)
            LOAD_X: begin
                LX = 1'b1;
            end
            MUL_A: begin
                // S = A * X
                M0 = 2'b01;
                H  = 1'b1;
                LS = 1'b1;
            end
            ADD_B: begin
                // S = S + B
                M0 = 2'b10;
                M2 = 2'b10;
                LS = 1'b1;
            end
            MUL_X: begin
                // S = S * X
                M1 = 2'b01;
                M2 = 2'b10;
                H  = 1'b1;
                LS = 1'b1;
            end
            ADD_C: begin
                // S = S + C
                M0 = 2'b11;
                M2 = 2'b10;
                LS = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            ERROR: begin
`ifdef OVERFLOW_ABORT_EN
                err = 1'b1;
`endif
            end
            default: begin
            end
        endcase
    end

    // Sticky status: ovf_flag spans one evaluation, zero_flag samples the final Reg_S.
    always_ff @(posedge clk) begin
        if (!rst) begin
            zero_flag <= 1'b0;
            ovf_flag  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                ovf_flag <= 1'b0;
            end else if (alu_state && overflow) begin
                ovf_flag <= 1'b1;
            end
            if (state == DONE) begin
                zero_flag <= zero;
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized self-checking bench for control_unit.
// Wraps the controller with a behavioural 16-bit datapath and compares against an arithmetic model.
// Stimulus is driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       zero;
    logic       overflow;
    logic       LX, LS, LH, H;
    logic [1:0] M0, M1, M2;
    logic       busy, done, err, zero_flag, ovf_flag;

    int npass  = 0;
    int ntotal = 0;

    logic exp_zflag = 1'b0;
    logic exp_oflag = 1'b0;

    control_unit dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .zero      (zero),
        .overflow  (overflow),
        .LX        (LX),
        .LS        (LS),
        .LH        (LH),
        .H         (H),
        .M0        (M0),
        .M1        (M1),
        .M2        (M2),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: operand muxes, add/multiply ALU, Reg_X and Reg_S.
    logic [15:0] A, B, C, X;
    logic [15:0] reg_x = 16'h0;
    logic [15:0] reg_s = 16'h0;
    logic [15:0] sel_abc, opnd_p, opnd_q;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        ovf_noise;

    always_comb begin
        case (M0)
            2'b01:   sel_abc = A;
            2'b10:   sel_abc = B;
            2'b11:   sel_abc = C;
            default: sel_abc = 16'h0;
        endcase
        if (M2 == 2'b10) begin
            opnd_p = reg_s;
            opnd_q = (M1 == 2'b01) ? reg_x : sel_abc;
        end else begin
            opnd_p = sel_abc;
            opnd_q = reg_x;
        end
        alu_res  = H ? ({16'h0, opnd_p} * {16'h0, opnd_q}) : ({16'h0, opnd_p} + {16'h0, opnd_q});
        alu_ovf  = (alu_res[31:16] != 16'h0);
        // Outside ALU steps the flag carries random noise that the controller must ignore.
        overflow = LS ? alu_ovf : ovf_noise;
        zero     = (reg_s == 16'h0);
    end

    always @(posedge clk) begin
        if (LX) reg_x <= X;
        if (LS) reg_s <= alu_res[15:0];
    end

    logic [12:0] act_vec;
    assign act_vec = {LX, LS, LH, H, M0, M1, M2, busy, done, err};

    // Expected {LX,LS,LH,H,M0,M1,M2,busy,done,err}; 0 IDLE,1 LOAD_X,2 MUL_A,3 ADD_B,4 MUL_X,5 ADD_C,6 DONE,7 ERROR.
    function automatic logic [12:0] exp_vec(input int ph);
        case (ph)
            1:       return 13'b1_0_0_0_00_00_00_1_0_0;
            2:       return 13'b0_1_0_1_01_00_00_1_0_0;
            3:       return 13'b0_1_0_0_10_00_10_1_0_0;
            4:       return 13'b0_1_0_1_00_01_10_1_0_0;
            5:       return 13'b0_1_0_0_11_00_10_1_0_0;
            6:       return 13'b0_0_0_0_00_00_00_1_1_0;
            7:       return 13'b0_0_0_0_00_00_00_1_0_1;
            default: return 13'b0;
        endcase
    endfunction

    function automatic logic [15:0] rand_op();
        logic [31:0] r;
        r = $urandom;
        if (r[31]) return 16'($urandom_range(0, 15));
        return r[15:0];
    endfunction

    // One evaluation from IDLE back to IDLE. mode 0: single start pulse;
    // 1: start held high throughout; 2: random start pulses while busy.
    task automatic run_eval(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input logic [15:0] x, input int mode, input string tag);
        logic [31:0] s;
        logic [3:0]  ov;
        logic [15:0] res;
        int          abort_at;
        int          ph_q[$];
        int          ph;

        s     = {16'h0, a} * {16'h0, x};
        ov[0] = (s[31:16] != 16'h0);
        s     = {16'h0, s[15:0]} + {16'h0, b};
        ov[1] = (s[31:16] != 16'h0);
        s     = {16'h0, s[15:0]} * {16'h0, x};
        ov[2] = (s[31:16] != 16'h0);
        s     = {16'h0, s[15:0]} + {16'h0, c};
        ov[3] = (s[31:16] != 16'h0);
        res   = s[15:0];

        abort_at = 4;
`ifdef OVERFLOW_ABORT_EN
        for (int k = 3; k >= 0; k--) begin
            if (ov[k]) abort_at = k;
        end
`endif
        ph_q.push_back(1);
        for (int k = 0; k < 4; k++) begin
            if (k <= abort_at) ph_q.push_back(k + 2);
        end
        ph_q.push_back((abort_at < 4) ? 7 : 6);

        // Entry: controller must be idle with the previous evaluation's flags.
        ntotal++;
        if ({act_vec, zero_flag, ovf_flag} !== {13'b0, exp_zflag, exp_oflag})
            $display("FAIL %s idle_entry: got vec=%b zf=%b of=%b, want vec=%b zf=%b of=%b",
                     tag, act_vec, zero_flag, ovf_flag, 13'b0, exp_zflag, exp_oflag);
        else npass++;

        A = a; B = b; C = c; X = x;
        start     = 1'b1;
        ovf_noise = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        exp_oflag = 1'b0;

        foreach (ph_q[i]) begin
            ph = ph_q[i];
            ntotal++;
            if ({act_vec, zero_flag, ovf_flag} !== {exp_vec(ph), exp_zflag, exp_oflag})
                $display("FAIL %s phase%0d(state %0d): got vec=%b zf=%b of=%b, want vec=%b zf=%b of=%b",
                         tag, i, ph, act_vec, zero_flag, ovf_flag, exp_vec(ph), exp_zflag, exp_oflag);
            else npass++;
            if (ph == 6) begin
                ntotal++;
                if (reg_s !== res)
                    $display("FAIL %s result: got %h, want %h", tag, reg_s, res);
                else npass++;
            end
            if (ph >= 2 && ph <= 5 && ov[ph-2]) exp_oflag = 1'b1;
            case (mode)
                1:       start = 1'b1;
                2:       start = 1'($urandom);
                default: start = 1'b0;
            endcase
            ovf_noise = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        if (ph == 6) exp_zflag = (res == 16'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; ovf_noise = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        exp_zflag = 1'b0; exp_oflag = 1'b0;
        ntotal++;
        if ({act_vec, zero_flag, ovf_flag} !== 15'b0)
            $display("FAIL reset_hold: got vec=%b zf=%b of=%b, want all 0", act_vec, zero_flag, ovf_flag);
        else npass++;
        // start was high during the reset edges and must have been dropped.
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ntotal++;
        if ({act_vec, zero_flag, ovf_flag} !== 15'b0)
            $display("FAIL reset_release: got vec=%b zf=%b of=%b, want all 0", act_vec, zero_flag, ovf_flag);
        else npass++;
    endtask

    task automatic test_nominal();
        run_eval(16'd2, 16'd3, 16'd4, 16'd5, 0, "nominal");
        ntotal++;
        if ({zero_flag, ovf_flag} !== 2'b00)
            $display("FAIL nominal_flags: got zf=%b of=%b, want zf=0 of=0", zero_flag, ovf_flag);
        else npass++;
    endtask

    task automatic test_zero();
        run_eval(16'd0, 16'd0, 16'd0, 16'd7, 0, "zero");
        ntotal++;
        if (zero_flag !== 1'b1)
            $display("FAIL zero_flag: got %b, want 1", zero_flag);
        else npass++;
    endtask

    task automatic test_overflow();
        run_eval(16'h4000, 16'h0, 16'h0, 16'd8, 0, "overflow");
        ntotal++;
        if (ovf_flag !== 1'b1)
            $display("FAIL ovf_flag: got %b, want 1", ovf_flag);
        else npass++;
    endtask

    task automatic test_reset_mid();
        A = 16'd2; B = 16'd3; C = 16'd4; X = 16'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        ntotal++;
        if (act_vec !== exp_vec(4))
            $display("FAIL mid_reset_pre: got vec=%b, want %b", act_vec, exp_vec(4));
        else npass++;
        rst = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_zflag = 1'b0; exp_oflag = 1'b0;
        ntotal++;
        if ({act_vec, zero_flag, ovf_flag} !== 15'b0)
            $display("FAIL mid_reset_abort: got vec=%b zf=%b of=%b, want all 0", act_vec, zero_flag, ovf_flag);
        else npass++;
        rst = 1'b1; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ntotal++;
        if ({act_vec, zero_flag, ovf_flag} !== 15'b0)
            $display("FAIL mid_reset_idle: got vec=%b zf=%b of=%b, want all 0", act_vec, zero_flag, ovf_flag);
        else npass++;
        run_eval(16'd2, 16'd3, 16'd4, 16'd5, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) run_eval(rand_op(), rand_op(), rand_op(), rand_op(), 1, "held_start");
        for (int i = 0; i < 2; i++) run_eval(rand_op(), rand_op(), rand_op(), rand_op(), 2, "busy_start");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++)
            run_eval(rand_op(), rand_op(), rand_op(), rand_op(), 2 * int'($urandom_range(0, 1)), "random");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ovf_noise = 1'b0;
        A = 16'h0; B = 16'h0; C = 16'h0; X = 16'h0;
        test_reset();
        test_nominal();
        test_zero();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_random();
        start = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
